// File: rtl/arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks of the datapath
// library.
//   sub_state_t : controller states of the bit-serial subtractor
//   cnt_w(n)    : width of a bit counter that must reach n-1, never below 1
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle between a controller and serial_subtractor.
//   start       : controller -> subtractor, request (taken in IDLE or DONE)
//   minuend     : controller -> subtractor, operand A
//   subtrahend  : controller -> subtractor, operand B
//   busy        : subtractor -> controller, serial computation in progress
//   done        : subtractor -> controller, one-cycle result-valid pulse
//   difference  : subtractor -> controller, (A - B) mod 2^N
//   borrow_out  : subtractor -> controller, 1 iff A < B
// Handshake: a request is accepted on a rising edge where start = 1 and the
// subtractor is in IDLE or DONE; start in any other cycle is dropped, never
// queued. Results are valid from the done pulse until the next acceptance.
interface serial_subtractor_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] minuend;
  logic [N-1:0] subtrahend;
  logic         busy;
  logic         done;
  logic [N-1:0] difference;
  logic         borrow_out;

  modport master (
    output start, minuend, subtrahend,
    input  busy, done, difference, borrow_out
  );

  modport slave (
    input  start, minuend, subtrahend,
    output busy, done, difference, borrow_out
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: minuend - subtrahend, LSB first, one bit
// per clock through a single full_subtractor cell and a borrow flop.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/done handshake, operands and results (slave side)
//   state_o  : current controller state, for observation
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus,
  output sub_state_t           state_o
);

  localparam int CW = cnt_w(N);

  sub_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          bor_q, bor_d;
  logic [N-1:0]  res_q, res_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;

  logic fs_d;
  logic fs_bout;
  logic load;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bor_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    bor_d   = bor_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    load    = 1'b0;

    unique case (state_q)
      IDLE: load = bus.start;
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bor_d = fs_bout;
        // Result fills from the top, so after N shifts bit 0 sits at LSB.
        res_d = {fs_d, res_q[N-1:1]};
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = {fs_d, res_q[N-1:1]};
          bout_d  = fs_bout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        load    = bus.start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_d     = bus.minuend;
      b_d     = bus.subtrahend;
      bor_d   = 1'b0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bor_q   <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bor_q   <= bor_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // busy spans edges k+1..k+N-1 after a start accepted at edge k; the first
  // RUN cycle is already covered by the acceptance itself, and start is
  // ignored there like in the rest of RUN.
  assign bus.busy       = (state_q == RUN) && (cnt_q != '0);
  assign bus.done       = (state_q == DONE);
  assign bus.difference = diff_q;
  assign bus.borrow_out = bout_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import arith_pkg::*;

  logic clk;
  logic rst;
  sub_state_t st8, st16;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_subtractor_if #(.N(8))  if8 ();
  serial_subtractor_if #(.N(16)) if16 ();

  serial_subtractor #(.N(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if8),
    .state_o (st8)
  );

  serial_subtractor #(.N(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if16),
    .state_o (st16)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [16:0] ref_sub(input int unsigned a, input int unsigned b,
                                          input int n);
    int unsigned m;
    int unsigned r;
    m = (32'd1 << n) - 1;
    r = (a + (m + 1) - b) & m;
    return {(a < b) ? 1'b1 : 1'b0, 16'(r)};
  endfunction

  // ---------------- drivers ----------------
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int nbusy,
                        output logic [7:0] d, output logic bo, output bit ok);
    @(negedge clk);
    if8.minuend = a; if8.subtrahend = b; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0; nbusy = 0; ok = 1'b0; d = '0; bo = 1'b0;
    if (if8.busy) nbusy++;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (if8.done) begin
        ok = 1'b1; d = if8.difference; bo = if8.borrow_out;
      end else if (if8.busy) nbusy++;
    end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [15:0] d,
                         output logic bo, output bit ok);
    @(negedge clk);
    if16.minuend = a; if16.subtrahend = b; if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    lat = 0; ok = 1'b0; d = '0; bo = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (if16.done) begin
        ok = 1'b1; d = if16.difference; bo = if16.borrow_out;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    if8.start = 1'b0; if8.minuend = '0; if8.subtrahend = '0;
    if16.start = 1'b0; if16.minuend = '0; if16.subtrahend = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if8.busy, if8.done, if8.difference, if8.borrow_out} !== 11'd0) begin
      n_fail++; $display("FAIL reset8_outputs got %h want 0",
                         {if8.busy, if8.done, if8.difference, if8.borrow_out});
    end
    n_cmp++;
    if (st8 !== IDLE) begin
      n_fail++; $display("FAIL reset8_state got %0d want %0d", st8, IDLE);
    end
    n_cmp++;
    if ({if16.busy, if16.done, if16.difference, if16.borrow_out} !== 19'd0) begin
      n_fail++; $display("FAIL reset16_outputs got %h want 0",
                         {if16.busy, if16.done, if16.difference, if16.borrow_out});
    end
    rst = 1'b0;
  endtask

  task automatic test_vector8(input string name, input logic [7:0] a, input logic [7:0] b);
    int lat, nbusy; logic [7:0] d; logic bo; bit ok; logic [16:0] exp;
    exp = ref_sub(a, b, 8);
    issue8(a, b, lat, nbusy, d, bo, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL %s_done_timeout got no done want done", name);
    end
    n_cmp++;
    if ({bo, d} !== {exp[16], exp[7:0]}) begin
      n_fail++; $display("FAIL %s_result got bo=%0b d=%h want bo=%0b d=%h",
                         name, bo, d, exp[16], exp[7:0]);
    end
    n_cmp++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL %s_latency got %0d want 8", name, lat);
    end
    n_cmp++;
    if (nbusy !== 7) begin
      n_fail++; $display("FAIL %s_busy_cycles got %0d want 7", name, nbusy);
    end
    @(negedge clk);
    n_cmp++;
    if ({if8.done, if8.busy, st8} !== {1'b0, 1'b0, IDLE}) begin
      n_fail++; $display("FAIL %s_after_done got done=%0b busy=%0b st=%0d want 0 0 %0d",
                         name, if8.done, if8.busy, st8, IDLE);
    end
    n_cmp++;
    if ({if8.borrow_out, if8.difference} !== {exp[16], exp[7:0]}) begin
      n_fail++; $display("FAIL %s_hold got %h want %h", name,
                         {if8.borrow_out, if8.difference}, {exp[16], exp[7:0]});
    end
  endtask

  task automatic test_start_in_run();
    int lat; bit ok; logic [7:0] d; logic bo;
    @(negedge clk);
    if8.minuend = 8'h33; if8.subtrahend = 8'h11; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    if8.minuend = 8'h01; if8.subtrahend = 8'h02; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 4; ok = 1'b0; d = '0; bo = 1'b0;
    if (if8.done) begin ok = 1'b1; d = if8.difference; bo = if8.borrow_out; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (if8.done) begin ok = 1'b1; d = if8.difference; bo = if8.borrow_out; end
    end
    n_cmp++;
    if ({ok, bo, d} !== {1'b1, 1'b0, 8'h22}) begin
      n_fail++; $display("FAIL start_in_run_result got ok=%0b bo=%0b d=%h want 1 0 22",
                         ok, bo, d);
    end
    n_cmp++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL start_in_run_latency got %0d want 8", lat);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (st8 !== IDLE) begin
      n_fail++; $display("FAIL start_in_run_not_queued got st=%0d want %0d", st8, IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nbusy; logic [7:0] d; logic bo; bit ok;
    issue8(8'h5A, 8'h23, lat, nbusy, d, bo, ok);
    n_cmp++;
    if ({ok, bo, d} !== {1'b1, 1'b0, 8'h37}) begin
      n_fail++; $display("FAIL b2b_first got ok=%0b bo=%0b d=%h want 1 0 37", ok, bo, d);
    end
    // Now in the DONE cycle: request again immediately.
    if8.minuend = 8'h10; if8.subtrahend = 8'h20; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    n_cmp++;
    if ({st8, if8.difference} !== {RUN, 8'h37}) begin
      n_fail++; $display("FAIL b2b_accept got st=%0d d=%h want %0d 37",
                         st8, if8.difference, RUN);
    end
    lat = 0; ok = 1'b0; d = '0; bo = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (if8.done) begin ok = 1'b1; d = if8.difference; bo = if8.borrow_out; end
    end
    n_cmp++;
    if ({ok, bo, d} !== {1'b1, 1'b1, 8'hF0}) begin
      n_fail++; $display("FAIL b2b_second got ok=%0b bo=%0b d=%h want 1 1 f0", ok, bo, d);
    end
    n_cmp++;
    if (lat !== 8) begin
      n_fail++; $display("FAIL b2b_latency got %0d want 8", lat);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    if8.minuend = 8'h5A; if8.subtrahend = 8'h23; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({if8.busy, if8.done, if8.difference, if8.borrow_out, st8} !== {11'd0, IDLE}) begin
      n_fail++; $display("FAIL reset_mid_outputs got b=%0b dn=%0b d=%h bo=%0b st=%0d want all 0",
                         if8.busy, if8.done, if8.difference, if8.borrow_out, st8);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_done got %0d pulses want 0", seen);
    end
    test_vector8("after_reset", 8'hC3, 8'h3C);
  endtask

  task automatic test_random16();
    logic [15:0] exp_q[$];
    logic        expb_q[$];
    logic [15:0] a, b, d, ed;
    logic        bo, eb;
    logic [16:0] r;
    int lat; bit ok;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 10 == 0) b = a;
      if (i % 10 == 1) a = 16'($urandom_range(0, 3));
      r = ref_sub(a, b, 16);
      exp_q.push_back(r[15:0]);
      expb_q.push_back(r[16]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue16(a, b, lat, d, bo, ok);
      ed = exp_q.pop_front();
      eb = expb_q.pop_front();
      n_cmp++;
      if ({ok, bo, d} !== {1'b1, eb, ed}) begin
        n_fail++; $display("FAIL rand16_%0d got ok=%0b bo=%0b d=%h want 1 %0b %h (a=%h b=%h)",
                           i, ok, bo, d, eb, ed, a, b);
      end
      n_cmp++;
      if (lat !== 16) begin
        n_fail++; $display("FAIL rand16_lat_%0d got %0d want 16", i, lat);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_vector8("basic", 8'h5A, 8'h23);
    test_vector8("underflow", 8'h00, 8'h01);
    test_vector8("equal", 8'hFF, 8'hFF);
    test_vector8("zero_b", 8'h80, 8'h00);
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
